// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the pipelined single-port SRAM (sram_sp_pipe) and its
// storage array (sram_mem_array).
//   state_e      : top-level sequencer states (zero-fill, then normal service)
//   MAX_NB/DW    : widest lane count / data width the helpers support
//   lane_count() : byte lanes for a given data width (NB = DW/8)
//   expand_mask(): widens a per-byte-lane mask into a per-bit mask
// ---------------------------------------------------------------------------
package sram_pkg;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  localparam int MAX_NB = 32;
  localparam int MAX_DW = 8 * MAX_NB;

  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

  // Callers zero-extend their NB-bit mask and keep the low DW bits of the
  // result, so one fixed-width helper serves every parameterisation.
  function automatic logic [MAX_DW-1:0] expand_mask(input logic [MAX_NB-1:0] bmask);
    logic [MAX_DW-1:0] bit_mask;
    bit_mask = '0;
    for (int k = 0; k < MAX_NB; k++) begin
      bit_mask[8*k +: 8] = {8{bmask[k]}};
    end
    return bit_mask;
  endfunction

endpackage

// File: rtl/sram_mem_array.sv
// ---------------------------------------------------------------------------
// sram_mem_array
// Plain synchronous storage of DEPTH words with per-byte-lane write enables
// and a registered read port. No reset: contents are only defined once
// written (the parent's zero-fill takes care of that).
// Ports:
//   i_clk      clock, rising edge
//   i_we       write strobe
//   i_lane_we  per-lane write enables (NB bits)
//   i_addr     word address (IW bits, must be < DEPTH when used)
//   i_wdata    write data (DW bits)
//   i_re       read strobe; the read register only loads when this is high
//   o_rdata    registered read data, holds between reads
// ---------------------------------------------------------------------------
module sram_mem_array #(
  parameter int DEPTH = 1024,
  parameter int IW    = 10,
  parameter int DW    = 32,
  parameter int NB    = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [NB-1:0] i_lane_we,
  input  logic [IW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  // Holding the read register when idle keeps the parent's output stable
  // without needing an extra output flop.
  always_comb begin
    rdata_d = rdata_q;
    if (i_re) begin
      rdata_d = mem[i_addr];
    end
  end

  // Writes commit at the edge they are presented; a read issued on the
  // following cycle therefore already sees the new word.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NB; k++) begin
      if (i_we && i_lane_we[k]) begin
        mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/sram_sp_pipe.sv
// ---------------------------------------------------------------------------
// sram_sp_pipe
// Single-port, byte-masked SRAM behind a valid/ready request port, with a
// configurable read latency (RD_LAT = 1..3), out-of-range flagging and an
// optional zero-fill sequence after reset.
// Ports:
//   i_clk, i_reset   clock (rising) / asynchronous active-high reset
//   i_req_valid      request present
//   o_req_ready      request can be accepted (high only in S_RUN)
//   i_addr           word address (AW bits)
//   i_wren           1 = write, 0 = read
//   i_bmask          byte-lane enables (write lanes / read lanes to return)
//   i_wdata          write data
//   o_rdata          read data, holds while o_rvalid is low
//   o_rvalid         read response pulse, RD_LAT cycles after acceptance
//   o_err            out-of-range pulse, aligned with the response slot
//   o_init_done      high once the fill has finished, until next reset
// ---------------------------------------------------------------------------
module sram_sp_pipe
  import sram_pkg::*;
#(
  parameter int AW        = 10,
  parameter int DEPTH     = 1024,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int INIT_ZERO = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [AW-1:0]       i_addr,
  input  logic                i_wren,
  input  logic [DW/8-1:0]     i_bmask,
  input  logic [DW-1:0]       i_wdata,
  output logic [DW-1:0]       o_rdata,
  output logic                o_rvalid,
  output logic                o_err,
  output logic                o_init_done
);

  localparam int NB = lane_count(DW);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  // Illegal parameter sets are stopped at elaboration.
  if (RD_LAT < 1 || RD_LAT > 3 || (DW % 8) != 0 || DW < 8 || DW > MAX_DW ||
      AW < 1 || DEPTH < 1 || longint'(DEPTH) > (longint'(1) << AW)) begin : g_bad_params
    $error("sram_sp_pipe: illegal parameters (RD_LAT 1..3, DW multiple of 8, DEPTH <= 2**AW)");
  end

  state_e            state_q, state_d;
  logic [IW-1:0]     fill_cnt_q, fill_cnt_d;
  logic              ready_q, ready_d;
  logic              init_done_q, init_done_d;
  logic              fill_active;

  logic              in_range;
  logic              accept;
  logic              rd_accept;
  logic              wr_commit;

  logic              mem_we;
  logic              mem_re;
  logic [NB-1:0]     mem_lane_we;
  logic [IW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  logic [MAX_DW-1:0] mask_full;
  logic [DW-1:0]     mask_q, mask_d;
  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [RD_LAT-1:0] err_q, err_d;
  logic [DW-1:0]     stage1_data;
  logic [DW-1:0]     rdata_out;

  if (DW < MAX_DW) begin : g_unused_hi
    logic unused_mask_hi;
    assign unused_mask_hi = ^mask_full[MAX_DW-1:DW];
  end

  // Zero-extended compare so DEPTH == 2**AW still fits.
  assign in_range  = ({1'b0, i_addr} < DEPTH_LIM);
  assign accept    = i_req_valid & ready_q;
  assign rd_accept = accept & ~i_wren;
  assign wr_commit = accept & i_wren & in_range;

  // Sequencer: the fill counter walks 0..DEPTH-1 and saturates on the last
  // word, which is the cycle the state flips to S_RUN. Ready and init_done
  // are registered copies of the next state so they rise together.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    fill_active = 1'b0;
    case (state_q)
      S_INIT: begin
        if (INIT_ZERO != 0) begin
          fill_active = 1'b1;
          if (fill_cnt_q == IW'(DEPTH - 1)) begin
            state_d = S_RUN;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
    ready_d     = (state_d == S_RUN);
    init_done_d = (state_d == S_RUN);
  end

  // Storage port: the fill owns the array in S_INIT, requests own it in
  // S_RUN; the two never overlap because ready is low during the fill.
  always_comb begin
    mask_full   = expand_mask(MAX_NB'(i_bmask));
    mem_we      = fill_active | wr_commit;
    mem_re      = rd_accept & in_range;
    mem_lane_we = fill_active ? '1 : i_bmask;
    mem_addr    = fill_active ? fill_cnt_q : i_addr[IW-1:0];
    mem_wdata   = fill_active ? '0 : i_wdata;
  end

  // First response stage lines up with the array's registered read. An
  // out-of-range read gets an all-zero mask, so its data comes back as 0.
  always_comb begin
    mask_d = mask_q;
    if (rd_accept) begin
      mask_d = in_range ? mask_full[DW-1:0] : '0;
    end
    valid_d    = '0;
    err_d      = '0;
    valid_d[0] = rd_accept;
    err_d[0]   = accept & ~in_range;
    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
    end
  end

  assign stage1_data = mem_rdata & mask_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_INIT;
      fill_cnt_q  <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      mask_q      <= '0;
      valid_q     <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      mask_q      <= mask_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  // Extra data stages only advance when their input stage carries a valid
  // response, which keeps the last returned word on o_rdata between reads.
  if (RD_LAT > 1) begin : g_pipe
    logic [RD_LAT-2:0][DW-1:0] data_q, data_d;

    always_comb begin
      data_d = data_q;
      if (valid_q[0]) begin
        data_d[0] = stage1_data;
      end
      for (int i = 1; i < RD_LAT - 1; i++) begin
        if (valid_q[i]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign rdata_out = data_q[RD_LAT-2];
  end else begin : g_no_pipe
    assign rdata_out = stage1_data;
  end

  sram_mem_array #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .DW    (DW),
    .NB    (NB)
  ) u_mem (
    .i_clk     (i_clk),
    .i_we      (mem_we),
    .i_lane_we (mem_lane_we),
    .i_addr    (mem_addr),
    .i_wdata   (mem_wdata),
    .i_re      (mem_re),
    .o_rdata   (mem_rdata)
  );

  assign o_req_ready = ready_q;
  assign o_init_done = init_done_q;
  assign o_rvalid    = valid_q[RD_LAT-1];
  assign o_err       = err_q[RD_LAT-1];
  assign o_rdata     = rdata_out;

endmodule

// File: tb/tb_sram_sp_pipe.sv
// ---------------------------------------------------------------------------
// tb_sram_sp_pipe
// Directed bench for sram_sp_pipe with DW=32, DEPTH=16, AW=5, RD_LAT=2,
// INIT_ZERO=1. Inputs change 1 time unit after each rising edge and outputs
// are sampled at the same point, i.e. they show what the last edge produced.
// ---------------------------------------------------------------------------
module tb_sram_sp_pipe;

  localparam int AW     = 5;
  localparam int DEPTH  = 16;
  localparam int DW     = 32;
  localparam int NB     = 4;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] addr;
  logic          wren;
  logic [NB-1:0] bmask;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          err;
  logic          init_done;

  int            num_cmp = 0;
  int            num_err = 0;
  int            ready_cycles;
  logic          saw_rvalid;
  logic          early_done;
  logic [31:0]   exp_mem [16];

  sram_pkg_free_clock: assert property (@(posedge clk) 1'b1);

  sram_sp_pipe #(
    .AW        (AW),
    .DEPTH     (DEPTH),
    .DW        (DW),
    .RD_LAT    (RD_LAT),
    .INIT_ZERO (1)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_addr      (addr),
    .i_wren      (wren),
    .i_bmask     (bmask),
    .i_wdata     (wdata),
    .o_rdata     (rdata),
    .o_rvalid    (rvalid),
    .o_err       (err),
    .o_init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [AW-1:0] a,
                               input logic [NB-1:0] m, input logic [DW-1:0] d);
    req_valid = v;
    wren      = we;
    addr      = a;
    bmask     = m;
    wdata     = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_cmp++;
    assert (obs === exp) else begin
      num_err++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [NB-1:0] m, input logic [DW-1:0] d);
    applyStimulus(1'b1, 1'b1, a, m, d);
    tick();
    idle();
  endtask

  // Read with RD_LAT=2: nothing one cycle after acceptance, response the next.
  task automatic doRead(input string tag, input logic [AW-1:0] a, input logic [NB-1:0] m,
                        input logic [DW-1:0] exp_data, input logic exp_err);
    applyStimulus(1'b1, 1'b0, a, m, '0);
    tick();
    checkOutput({tag, ".early_rvalid"}, 32'(rvalid), 32'd0);
    idle();
    tick();
    checkOutput({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    checkOutput({tag, ".rdata"}, rdata, exp_data);
    checkOutput({tag, ".err"}, 32'(err), 32'(exp_err));
  endtask

  // Counts cycles after reset release until ready rises (bounded at 40).
  task automatic waitReady(output int cycles, output logic any_rvalid, output logic done_early);
    cycles     = 0;
    any_rvalid = 1'b0;
    done_early = 1'b0;
    while (cycles < 40) begin
      tick();
      cycles++;
      if (rvalid) any_rvalid = 1'b1;
      if (init_done && !req_ready) done_early = 1'b1;
      if (req_ready) break;
    end
  endtask

  initial begin
    foreach (exp_mem[i]) exp_mem[i] = 32'h0;
    exp_mem[0] = 32'h000000A0;
    exp_mem[1] = 32'h000000A1;
    exp_mem[2] = 32'h000000A2;
    exp_mem[3] = 32'h000000A3;
    exp_mem[7] = 32'h12345678;

    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.ready", 32'(req_ready), 32'd0);
    checkOutput("rst.rvalid", 32'(rvalid), 32'd0);
    checkOutput("rst.err", 32'(err), 32'd0);
    checkOutput("rst.rdata", rdata, 32'h0);
    checkOutput("rst.init_done", 32'(init_done), 32'd0);

    // Zero-fill: 16 cycles of ready low, then ready and init_done together.
    reset = 1'b0;
    waitReady(ready_cycles, saw_rvalid, early_done);
    checkOutput("fill.cycles", 32'(ready_cycles), 32'd16);
    checkOutput("fill.init_done", 32'(init_done), 32'd1);
    checkOutput("fill.done_before_ready", 32'(early_done), 32'd0);
    doRead("zero5", 5'd5, 4'hF, 32'h00000000, 1'b0);

    // Partial write merge and masked reads.
    doWrite(5'd3, 4'hF, 32'hDEADBEEF);
    doWrite(5'd3, 4'h5, 32'h11223344);
    doRead("merge", 5'd3, 4'hF, 32'hDE22BE44, 1'b0);
    doRead("mask3", 5'd3, 4'h3, 32'h0000BE44, 1'b0);
    doRead("mask0", 5'd3, 4'h0, 32'h00000000, 1'b0);

    // Back-to-back writes then back-to-back reads, responses in order.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(i), 4'hF, 32'h000000A0 + 32'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 5'(i), 4'hF, '0);
      tick();
      if (i > 0) begin
        checkOutput($sformatf("stream%0d.rvalid", i - 1), 32'(rvalid), 32'd1);
        checkOutput($sformatf("stream%0d.rdata", i - 1), rdata, 32'h000000A0 + 32'(i - 1));
      end
    end
    idle();
    tick();
    checkOutput("stream3.rvalid", 32'(rvalid), 32'd1);
    checkOutput("stream3.rdata", rdata, 32'h000000A3);
    tick();
    checkOutput("hold.rvalid", 32'(rvalid), 32'd0);
    checkOutput("hold.rdata", rdata, 32'h000000A3);

    // Read directly after a write to the same address.
    doWrite(5'd7, 4'hF, 32'h12345678);
    doRead("raw7", 5'd7, 4'hF, 32'h12345678, 1'b0);

    // Out-of-range write: dropped, o_err two cycles after acceptance.
    applyStimulus(1'b1, 1'b1, 5'd20, 4'hF, 32'hFFFFFFFF);
    tick();
    checkOutput("oorw.early_err", 32'(err), 32'd0);
    idle();
    tick();
    checkOutput("oorw.err", 32'(err), 32'd1);
    checkOutput("oorw.rvalid", 32'(rvalid), 32'd0);
    tick();
    checkOutput("oorw.err_after", 32'(err), 32'd0);
    doRead("oorr", 5'd20, 4'hF, 32'h00000000, 1'b1);

    // Scan all words to confirm nothing was disturbed.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 5'(i), 4'hF, '0);
      tick();
      if (i > 0) begin
        checkOutput($sformatf("scan%0d.rvalid", i - 1), 32'(rvalid), 32'd1);
        checkOutput($sformatf("scan%0d.rdata", i - 1), rdata, exp_mem[i-1]);
      end
    end
    idle();
    tick();
    checkOutput("scan15.rvalid", 32'(rvalid), 32'd1);
    checkOutput("scan15.rdata", rdata, exp_mem[15]);

    // Reset one cycle after a read is accepted: its response must vanish.
    applyStimulus(1'b1, 1'b0, 5'd3, 4'hF, '0);
    tick();
    idle();
    reset = 1'b1;
    #1;
    checkOutput("midrst.rvalid", 32'(rvalid), 32'd0);
    checkOutput("midrst.err", 32'(err), 32'd0);
    tick();
    checkOutput("midrst.rvalid2", 32'(rvalid), 32'd0);
    checkOutput("midrst.ready", 32'(req_ready), 32'd0);
    checkOutput("midrst.init_done", 32'(init_done), 32'd0);
    tick();
    reset = 1'b0;
    waitReady(ready_cycles, saw_rvalid, early_done);
    checkOutput("refill.cycles", 32'(ready_cycles), 32'd16);
    checkOutput("refill.no_rvalid", 32'(saw_rvalid), 32'd0);
    checkOutput("refill.init_done", 32'(init_done), 32'd1);
    doRead("refill3", 5'd3, 4'hF, 32'h00000000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
    $finish;
  end

endmodule
